imem_boot_ctrl: RTL
===================

Name: imem_boot_ctrl

Overview:
- Sequencer in front of the instruction memory array in the fetch stage.
- Clears memory to NOP after reset, streams a host program image into it over a valid/ready port, then releases the core to fetch.
- Owns the single write port and the read address; the core is held stalled until the image is loaded and the RUN state is entered.
- Supports a re-load from RUN: the core is stalled, memory is reprogrammed, and fetch resumes.

Parameters:
- ADDR_W, `MEM_ADDR_WIDTH: word-address width; memory depth is 2^ADDR_W words.
- NOP_WORD, 32'h00000013: fill value written during CLEAR.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load_start  in  1  pulse; begin image load
- load_base  in  ADDR_W  first word address of image, sampled with load_start
- load_len  in  ADDR_W+1  image length in words (0..2^ADDR_W), sampled with load_start
- load_valid  in  1  host word valid
- load_data  in  32  host word
- load_ready  out  1  controller accepts word
- load_done  out  1  one-cycle pulse on load completion
- run_req  in  1  level; start core without loading (IDLE only)
- halt_req  in  1  level; return RUN to IDLE
- fetch_pc  in  32  byte PC from fetch
- core_run  out  1  high only in RUN; low = core stalled
- fetch_fault  out  1  RUN and fetch_pc[1:0] != 0
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  write word address
- mem_wdata  out  32  write data
- mem_raddr  out  ADDR_W  read word address = fetch_pc[ADDR_W+1:2]

Behaviour:
- Reset (async): state=CLEAR, cnt=0, pending=0. Outputs: load_ready=0, load_done=0, core_run=0, fetch_fault=0, mem_we=0, mem_waddr=0, mem_wdata=0. Reset asserted mid-LOAD aborts the load; the partial image is discarded by the next CLEAR.
- States: CLEAR, IDLE, LOAD, RUN.
- mem_raddr is combinational from fetch_pc in all states.
- Write signals are registered: a write decided in cycle N is presented on mem_* in cycle N+1.
- CLEAR:
  - One write per cycle: waddr=cnt, wdata=NOP_WORD; cnt increments.
  - After cnt = 2^ADDR_W-1 is issued, go to IDLE. Duration is exactly 2^ADDR_W cycles.
  - load_start during CLEAR sets pending and captures base/len. The load is serviced on CLEAR exit, and the CLEAR->LOAD transition bypasses IDLE.
- IDLE:
  - load_start has priority over run_req.
  - load_start with len!=0 -> LOAD (ptr=base, rem=len).
  - load_start with len==0 -> RUN, with load_done pulsed in the transition cycle.
  - run_req -> RUN.
- LOAD:
  - load_ready=1 while rem!=0.
  - On valid&&ready: write data at ptr; ptr=ptr+1 mod 2^ADDR_W (wraps); rem=rem-1.
  - The accept with rem==1 drives the state to RUN, load_ready to 0, and load_done to 1 for the following cycle.
  - valid without ready is ignored.
  - halt_req and load_start are ignored in LOAD.
- RUN:
  - core_run=1; fetch_fault = |fetch_pc[1:0].
  - load_start -> LOAD with core_run=0 from the next cycle; len==0 stays in RUN and pulses load_done.
  - halt_req -> IDLE. load_start has priority over halt_req when both are asserted.
- Counter width:
  - rem is ADDR_W+1 bits, so len=2^ADDR_W is legal and fills the whole array.
  - ptr is ADDR_W bits and wraps silently.

Decomposition:
- Shared package (riscv_defines / common): `MEM_ADDR_WIDTH, NOP encoding constant, state enum imem_boot_state_t {CLEAR, IDLE, LOAD, RUN}.
- No sub-module needed. An optional instance of the memory array, with its write port added, sits beside this block in the fetch top level.

Test Plan:
- Reset, ADDR_W=4 -> 16 cycles of mem_we=1 with waddr 0..15 and wdata 32'h00000013; then IDLE with core_run=0.
- IDLE, load_start base=2 len=3, words A,B,C with valid gaps -> writes at 2,3,4 in order; load_ready drops after C; load_done pulses once; core_run=1 the next cycle.
- Wrap case: base=14 len=4 (ADDR_W=4) -> writes at 14,15,0,1.
- load_start during CLEAR -> load begins immediately after the 16th CLEAR write, with no IDLE cycle.
- RUN, fetch_pc=32'h0000_0026 -> mem_raddr=9, fetch_fault=1. load_start len=1 in RUN -> core_run=0 next cycle; one word written; back to RUN.
- Reset asserted mid-LOAD after 1 of 3 words -> all outputs 0 immediately; CLEAR restarts at address 0.

Source files
------------

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-memory boot sequencer.
package imem_boot_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD,
        RUN
    } imem_boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Instruction memory boot sequencer: clears to NOP, streams a host image in,
// then releases the core to fetch. Owns the memory write port and read address.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = MEM_ADDR_WIDTH,
    parameter logic [31:0] NOP_WORD = NOP_INSN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              load_done,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic [31:0]       fetch_pc,
    output logic              core_run,
    output logic              fetch_fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr
);

    imem_boot_state_t  state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   rem;
    logic              pending;

    logic              accept;
    logic              go_pend;
    logic [ADDR_W:0]   go_len;
    logic              unused_pc;

    assign mem_raddr   = fetch_pc[ADDR_W+1:2];
    assign unused_pc   = ^fetch_pc[31:ADDR_W+2];
    assign core_run    = (state == RUN);
    assign load_ready  = (state == LOAD) && (rem != '0);
    assign fetch_fault = core_run && (|fetch_pc[1:0]);
    assign accept      = load_valid && load_ready;

    // A load_start on the final CLEAR cycle is serviced like an earlier one.
    assign go_pend = pending || load_start;
    assign go_len  = load_start ? load_len : rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            ptr       <= '0;
            rem       <= '0;
            pending   <= 1'b0;
            load_done <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            unique case (state)
                CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_waddr <= cnt;
                    mem_wdata <= NOP_WORD;
                    cnt       <= cnt + ADDR_W'(1);
                    if (load_start) begin
                        pending <= 1'b1;
                        ptr     <= load_base;
                        rem     <= load_len;
                    end
                    if (cnt == '1) begin
                        pending <= 1'b0;
                        if (!go_pend) begin
                            state <= IDLE;
                        end else if (go_len != '0) begin
                            state <= LOAD;
                        end else begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (load_start) begin
                        ptr <= load_base;
                        rem <= load_len;
                        if (load_len != '0) begin
                            state <= LOAD;
                        end else begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end else if (run_req) begin
                        state <= RUN;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= ptr;
                        mem_wdata <= load_data;
                        ptr       <= ptr + ADDR_W'(1);
                        rem       <= rem - (ADDR_W+1)'(1);
                        if (rem == (ADDR_W+1)'(1)) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_start) begin
                        ptr <= load_base;
                        rem <= load_len;
                        if (load_len != '0) begin
                            state <= LOAD;
                        end else begin
                            load_done <= 1'b1;
                        end
                    end else if (halt_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
